// File: rtl/bfp_frame_scaler_pkg.sv
// Shared types and elaboration-time helpers for the block-floating-point frame scaler.
package bfp_frame_scaler_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        CALC,
        DRAIN
    } state_e;

    // Bits needed to hold an MSB index in the range 0..width-2.
    function automatic int idx_width(input int width);
        return (width > 2) ? $clog2(width - 1) : 1;
    endfunction

    function automatic int cnt_width(input int frame);
        return $clog2(frame);
    endfunction

    // Right shift that brings the largest index into an out_w-bit signed mantissa.
    function automatic int calc_shift(input int max_idx, input int out_w);
        return (max_idx + 2 > out_w) ? (max_idx + 2 - out_w) : 0;
    endfunction

endpackage

// File: rtl/bfp_frame_scaler_if.sv
// Input sample stream and output mantissa stream of the frame scaler.
interface bfp_frame_scaler_if #(
    parameter int WIDTH = 23,
    parameter int OUT_W = 16,
    parameter int EXP_W = $clog2(WIDTH)
);
    logic                    s_valid;
    logic                    s_ready;
    logic [WIDTH-1:0]        s_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [OUT_W-1:0]        m_data;
    logic [EXP_W-1:0]        m_exp;
    logic                    m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_exp, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_exp, m_last
    );
endinterface

// File: rtl/bfp_frame_scaler_mag_detect.sv
// Per-sample magnitude index: highest bit below the sign bit that differs from the sign.
module bfp_frame_scaler_mag_detect #(
    parameter int WIDTH = 23,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [IDX_W-1:0] idx_o
);
    logic [WIDTH-2:0] diff;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_diff
            assign diff[gi] = data_i[gi] ^ data_i[WIDTH-1];
        end
    endgenerate

    // Ascending scan so the highest differing bit wins; 0 and -1 fall through to 0.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (diff[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/bfp_frame_scaler.sv
// Block-floating-point frame scaler: collect a frame, pick a shared exponent, drain scaled mantissas.
// Optional BFP_ROUND_EN: round-half-up before the shift with saturation; otherwise plain truncation.
module bfp_frame_scaler
    import bfp_frame_scaler_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int OUT_W = 16,
    parameter int FRAME = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    bfp_frame_scaler_if.slave    bus
);
    localparam int EXP_W = $clog2(WIDTH);
    localparam int IDX_W = idx_width(WIDTH);
    localparam int CNT_W = cnt_width(FRAME);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0]   max_idx_q, max_idx_d;
    logic [EXP_W-1:0]   shift_q, shift_d;

    logic [IDX_W-1:0]   s_idx;
    logic               buf_we;
    logic               m_valid_w;
    logic               m_last_w;
    logic [OUT_W-1:0]   scaled;

    logic [WIDTH-1:0]   frame_mem [FRAME];
    logic signed [WIDTH-1:0] rd_sample;

    bfp_frame_scaler_mag_detect #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_mag_detect (
        .data_i (bus.s_data),
        .idx_o  (s_idx)
    );

    always_ff @(posedge clk) begin
        if (buf_we) begin
            frame_mem[wr_cnt_q] <= bus.s_data;
        end
    end

    assign rd_sample = $signed(frame_mem[rd_cnt_q]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= COLLECT;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            max_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            max_idx_q <= max_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        max_idx_d   = max_idx_q;
        shift_d     = shift_q;
        buf_we      = 1'b0;
        bus.s_ready = 1'b0;
        m_valid_w   = 1'b0;
        m_last_w    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    buf_we    = 1'b1;
                    wr_cnt_d  = wr_cnt_q + 1'b1;
                    max_idx_d = (s_idx > max_idx_q) ? s_idx : max_idx_q;
                    if (wr_cnt_q == CNT_W'(FRAME - 1)) begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                shift_d = EXP_W'(calc_shift(int'(max_idx_q), OUT_W));
                state_d = DRAIN;
            end
            DRAIN: begin
                m_valid_w = 1'b1;
                m_last_w  = (rd_cnt_q == CNT_W'(FRAME - 1));
                if (bus.m_ready) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (m_last_w) begin
                        state_d   = COLLECT;
                        wr_cnt_d  = '0;
                        rd_cnt_d  = '0;
                        max_idx_d = '0;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

`ifdef BFP_ROUND_EN
    // One guard bit keeps the rounding add from wrapping at the positive full scale.
    logic signed [WIDTH:0]   ext_sample;
    logic signed [WIDTH:0]   rnd_add;
    logic signed [WIDTH:0]   shifted;
    logic [WIDTH-OUT_W+1:0]  hi_bits;
    logic                    ovf;

    assign ext_sample = {rd_sample[WIDTH-1], rd_sample};
    assign rnd_add    = (shift_q != '0) ? ((WIDTH+1)'(1) << (shift_q - 1'b1)) : '0;
    assign shifted    = (ext_sample + rnd_add) >>> shift_q;
    assign hi_bits    = shifted[WIDTH:OUT_W-1];
    assign ovf        = !((&hi_bits) || (~|hi_bits));
    assign scaled     = ovf ? {shifted[WIDTH], {(OUT_W-1){~shifted[WIDTH]}}}
                            : shifted[OUT_W-1:0];
`else
    logic signed [WIDTH-1:0] shifted;

    assign shifted = rd_sample >>> shift_q;
    assign scaled  = OUT_W'(shifted);
`endif

    assign bus.m_valid = m_valid_w;
    assign bus.m_last  = m_last_w;
    assign bus.m_data  = m_valid_w ? scaled : '0;
    assign bus.m_exp   = shift_q;
endmodule

// File: tb/tb_bfp_frame_scaler.sv
// Scoreboard bench for bfp_frame_scaler; expected mantissas come from a reference model per frame.
module tb_bfp_frame_scaler;
    localparam int WIDTH = 23;
    localparam int OUT_W = 16;
    localparam int FRAME = 16;

    typedef struct {
        int data;
        int last;
        int exp_v;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   out_count;
    exp_t sb[$];

    bfp_frame_scaler_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

    bfp_frame_scaler #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W),
        .FRAME (FRAME)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp_v);
        n_checks++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
        end
    endtask

    function automatic int model_idx(input int s);
        logic [WIDTH-1:0] v;
        v = WIDTH'(s);
        for (int b = WIDTH - 2; b >= 0; b--) begin
            if (v[b] != v[WIDTH-1]) return b;
        end
        return 0;
    endfunction

    function automatic int model_scale(input int s, input int sh);
        int r;
`ifdef BFP_ROUND_EN
        r = (sh > 0) ? ((s + (1 << (sh - 1))) >>> sh) : s;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`else
        r = s >>> sh;
`endif
        return r;
    endfunction

    // Monitor: pops the scoreboard on every transfer, checks idle zeros and held data.
    int  held_data;
    int  held_last;
    bit  hold_pend;
    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && bus.m_valid) begin
                check("hold_data", int'($signed(bus.m_data)), held_data);
                check("hold_last", int'(bus.m_last), held_last);
            end
            hold_pend = 1'b0;
            if (bus.m_valid) begin
                check("s_ready_in_drain", int'(bus.s_ready), 0);
                if (bus.m_ready) begin
                    $display("OUT data=%0d last=%0d exp=%0d", $signed(bus.m_data), bus.m_last, bus.m_exp);
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("m_data", int'($signed(bus.m_data)), e.data);
                        check("m_last", int'(bus.m_last), e.last);
                        check("m_exp", int'(bus.m_exp), e.exp_v);
                    end
                    out_count++;
                end else begin
                    held_data = int'($signed(bus.m_data));
                    held_last = int'(bus.m_last);
                    hold_pend = 1'b1;
                end
            end else begin
                check("idle_data_zero", int'(bus.m_data), 0);
                check("idle_last_zero", int'(bus.m_last), 0);
            end
        end
    end

    task automatic push_model(input int smp[FRAME]);
        int mx;
        int sh;
        mx = 0;
        foreach (smp[i]) begin
            if (model_idx(smp[i]) > mx) mx = model_idx(smp[i]);
        end
        sh = (mx + 2 > OUT_W) ? mx + 2 - OUT_W : 0;
        foreach (smp[i]) begin
            exp_t e;
            e.data  = model_scale(smp[i], sh);
            e.last  = (i == FRAME - 1) ? 1 : 0;
            e.exp_v = sh;
            sb.push_back(e);
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge; returns likewise after the handshake edge.
    task automatic send_sample(input int v, input bit gap);
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = WIDTH'(v);
        n = 0;
        while (!bus.s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("s_ready_timeout", 0, 1);
        $display("IN  data=%0d", v);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int smp[FRAME], input bit gap);
        push_model(smp);
        out_count = 0;
        foreach (smp[i]) send_sample(smp[i], gap);
    endtask

    task automatic wait_drain(input bit toggle);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            if (toggle) bus.m_ready = ~bus.m_ready;
            n++;
        end
        bus.m_ready = 1'b1;
        check("drain_done", sb.size(), 0);
        sb.delete();
        check("s_ready_after_drain", int'(bus.s_ready), 1);
    endtask

    initial begin
        int f[FRAME];
        int n;
        n_checks    = 0;
        n_fail      = 0;
        out_count   = 0;
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", int'(bus.s_ready), 1);
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_m_exp", int'(bus.m_exp), 0);
        check("rst_m_data", int'(bus.m_data), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: constant 100, plus latency of the first output
        foreach (f[i]) f[i] = 100;
        send_frame(f, 1'b0);
        check("calc_m_valid", int'(bus.m_valid), 0);
        check("calc_s_ready", int'(bus.s_ready), 0);
        @(posedge clk); #1;
        check("first_m_valid", int'(bus.m_valid), 1);
        wait_drain(1'b0);
        check("frame1_count", out_count, FRAME);

        // 2: positive full scale forces max shift
        foreach (f[i]) f[i] = 1000;
        f[0] = 4194303;
        send_frame(f, 1'b0);
        wait_drain(1'b0);

        // 3: negative full scale with -1 and 0 tails
        foreach (f[i]) f[i] = -1;
        f[0] = -4194304;
        f[FRAME-1] = 0;
        send_frame(f, 1'b0);
        wait_drain(1'b0);

        // 4: backpressure toggling during drain
        foreach (f[i]) f[i] = (i * 37111) - 300000;
        send_frame(f, 1'b0);
        wait_drain(1'b1);
        check("toggle_count", out_count, FRAME);

        // 5: reset after five outputs
        foreach (f[i]) f[i] = (i * 4001) - 30000;
        send_frame(f, 1'b0);
        n = 0;
        while (out_count < 5 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_reset_count", out_count, 5);
        reset = 1'b1;
        #1;
        check("midrst_m_valid", int'(bus.m_valid), 0);
        check("midrst_s_ready", int'(bus.s_ready), 1);
        check("midrst_m_data", int'(bus.m_data), 0);
        check("midrst_m_exp", int'(bus.m_exp), 0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        foreach (f[i]) f[i] = 5;
        send_frame(f, 1'b0);
        wait_drain(1'b0);
        check("post_reset_count", out_count, FRAME);

        // 6: all-zero frame with input gaps
        foreach (f[i]) f[i] = 0;
        send_frame(f, 1'b1);
        wait_drain(1'b0);
        check("zero_frame_count", out_count, FRAME);
        check("zero_frame_exp", int'(bus.m_exp), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
